// File: rtl/punc_fetch_unit.sv
// PUnC instruction fetch front end: issues in-order word fetches, buffers
// responses in a small prefetch queue, and discards stale fetches on redirect.
module punc_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        ir_valid,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  input  logic        ir_take,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   rsp_pc_q, rsp_pc_d;
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   pc_q   [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          push;
  logic          pop;

  // Queued plus in-flight entries are capped at DEPTH, so responses are never refused.
  assign occupancy      = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !rst && !halt && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push     = imem_rsp_valid && (drop_q == '0) && !redirect;
  assign ir_valid = (count_q != '0);
  assign pop      = ir_take && ir_valid && !redirect;
  assign ir       = ir_valid ? data_q[head_q] : '0;
  assign ir_pc    = ir_valid ? pc_q[head_q]   : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect) begin
      // Everything still in flight after this cycle predates the redirect.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      outst_d    = outst_q - CW'(imem_rsp_valid);
      drop_d     = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire)
        fetch_pc_d = fetch_pc_q + 16'd1;
      outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (push) begin
        tail_d   = tail_q + AW'(1);
        rsp_pc_d = rsp_pc_q + 16'd1;
      end
      if (pop)
        head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: reads are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= imem_rsp_data;
      pc_q[tail_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_punc_fetch_unit.sv
// Randomized and directed bench for punc_fetch_unit against a queue-based
// model of the fetch stream and an in-order variable-latency memory.
module tb_punc_fetch_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data  = '0;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_take = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;

  always #5 clk = ~clk;

  punc_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ir_valid       (ir_valid),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_take        (ir_take),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  typedef struct {logic [15:0] addr; int due; bit stale;} flight_t;
  typedef struct {logic [15:0] pc; logic [15:0] data;} ent_t;

  flight_t     flight[$];
  ent_t        q[$];
  logic [15:0] m_fetch = RST_PC;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        last_req_valid, last_ir_valid;
  logic [15:0] last_req_addr, last_ir, last_ir_pc;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] b16(input logic b);
    return {15'b0, b};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, then advance the model.
  task automatic step(input bit rdy, input bit take, input bit redir,
                      input logic [15:0] rpc, input bit hlt, input int lat);
    bit      rsp_now;
    bit      exp_rv;
    flight_t f;
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = rdy;
    ir_take        = take;
    redirect       = redir;
    redirect_pc    = rpc;
    halt           = hlt;
    rsp_now        = (flight.size() > 0) && (flight[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? memf(flight[0].addr) : 16'($urandom);
    #1;
    last_req_valid = imem_req_valid;
    last_req_addr  = imem_req_addr;
    last_ir_valid  = ir_valid;
    last_ir        = ir;
    last_ir_pc     = ir_pc;
    exp_rv = !hlt && !redir && ((q.size() + flight.size()) < DEPTH);
    check("req_valid", b16(imem_req_valid), b16(exp_rv));
    check("req_addr", imem_req_addr, m_fetch);
    check("ir_valid", b16(ir_valid), b16(q.size() != 0));
    check("ir", ir, (q.size() != 0) ? q[0].data : 16'h0000);
    check("ir_pc", ir_pc, (q.size() != 0) ? q[0].pc : 16'h0000);
    if (take && !redir && (q.size() != 0))
      void'(q.pop_front());
    if (rsp_now) begin
      f = flight.pop_front();
      if (!f.stale && !redir)
        q.push_back('{f.addr, memf(f.addr)});
    end
    if (redir) begin
      q.delete();
      foreach (flight[i]) flight[i].stale = 1'b1;
      m_fetch = rpc;
    end else if (exp_rv && rdy) begin
      flight.push_back('{m_fetch, cyc + lat, 1'b0});
      m_fetch = m_fetch + 16'd1;
    end
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_ir_valid", b16(ir_valid), 16'h0000);
    check("rst_req_valid", b16(imem_req_valid), 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_req_addr", imem_req_addr, RST_PC);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect       = 1'b0;
    ir_take        = 1'b0;
    halt           = 1'b0;
    flight.delete();
    q.delete();
    m_fetch = RST_PC;
    cyc     = 0;
    @(posedge clk);
  endtask

  task automatic wait_ir(input string tag, input logic [15:0] exp_pc);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1);
      if (last_ir_valid) break;
    end
    check({tag, "_pc"}, last_ir_pc, exp_pc);
    check({tag, "_ir"}, last_ir, memf(exp_pc));
  endtask

  initial begin
    bit hlt_r;
    repeat (2) @(posedge clk);
    #1;
    check("init_req_valid", b16(imem_req_valid), 16'h0000);
    check("init_req_addr", imem_req_addr, RST_PC);
    check("init_ir_valid", b16(ir_valid), 16'h0000);
    check("init_ir_pc", ir_pc, 16'h0000);

    // Free run with 1-cycle memory: first ir_valid in cycle 2.
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1);
      check($sformatf("first_valid_c%0d", c), b16(last_ir_valid), b16(c == 2));
    end
    repeat (27) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1);

    // Backpressure then release.
    repeat (12) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1);
    check("bp_full_no_req", b16(last_req_valid), 16'h0000);
    repeat (10) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1);

    // Redirect with two stale fetches on 3-cycle memory.
    for (int i = 0; i < 20; i++) begin
      if (flight.size() == 2) break;
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 3);
    end
    check("two_outstanding", 16'(flight.size()), 16'd2);
    step(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 3);
    wait_ir("stale_redir", 16'h0040);
    repeat (6) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1);

    // Redirect coinciding with a take and a response.
    repeat (8) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1);
    step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1);
    check("simul_had_rsp", b16(imem_rsp_valid), 16'h0001);
    check("simul_had_ir", b16(last_ir_valid), 16'h0001);
    wait_ir("simul_redir", 16'h1234);

    // Halt after three accepted requests across the address wrap.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1);
    repeat (8) step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1);
    check("halt_resume_valid", b16(last_req_valid), 16'h0001);
    check("halt_resume_addr", last_req_addr, 16'h0001);

    // Reset with three queued entries.
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 3) break;
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1);
    end
    check("three_queued", 16'(q.size()), 16'd3);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1);
    check("post_rst_addr", last_req_addr, RST_PC);

    // Random traffic.
    hlt_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) hlt_r = !hlt_r;
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, 16'($urandom), hlt_r,
           int'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
